// File: rtl/hpdcache_fence_seq.sv
// Fence sequencer: drains the store buffer, then optionally issues FLUSH and INVAL
// maintenance commands to the cache before acknowledging the fence.
module hpdcache_fence_seq #(
   parameter bit          FlushOnFence      = 1'b1,
   parameter bit          InvalidateOnFlush = 1'b0,
   parameter int unsigned TimeoutCycles     = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        fence_req_i,
   input  logic        fence_i_i,
   input  logic        sb_empty_i,
   output logic        cmd_valid_o,
   output logic        cmd_op_o,
   input  logic        cmd_ready_i,
   input  logic        cmd_done_i,
   output logic        fence_ack_o,
   output logic        err_o,
   output logic        busy_o,
   output logic [15:0] flush_cnt_o
);

   typedef enum logic [2:0] {
      IDLE, DRAIN, FLUSH_REQ, FLUSH_WAIT, INV_REQ, INV_WAIT, ACK
   } state_e;

   localparam logic [15:0] WdgLast = 16'(TimeoutCycles - 1);

   state_e      state_q, state_d;
   logic [15:0] wdg_q, wdg_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;
   logic        is_fencei_q, is_fencei_d;
   logic        err_q, err_d;
   logic        wdg_exp;
   logic        wdg_run;

   assign wdg_exp = (wdg_q == WdgLast);
   assign wdg_run = (state_q == DRAIN) || (state_q == FLUSH_WAIT) || (state_q == INV_WAIT);

   always_comb begin
      state_d     = state_q;
      is_fencei_d = is_fencei_q;
      flush_cnt_d = flush_cnt_q;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (fence_req_i) begin
               is_fencei_d = fence_i_i;
               state_d     = DRAIN;
            end
         end
         // Normal exits are tested before the watchdog so they win a tie.
         DRAIN: begin
            if (sb_empty_i) begin
               state_d = (FlushOnFence || is_fencei_q) ? FLUSH_REQ : ACK;
            end else if (wdg_exp) begin
               state_d = ACK;
               err_d   = 1'b1;
            end
         end
         FLUSH_REQ: begin
            if (cmd_ready_i) begin
               state_d = FLUSH_WAIT;
               if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
            end
         end
         FLUSH_WAIT: begin
            if (cmd_done_i) begin
               state_d = InvalidateOnFlush ? INV_REQ : ACK;
            end else if (wdg_exp) begin
               state_d = ACK;
               err_d   = 1'b1;
            end
         end
         INV_REQ: begin
            if (cmd_ready_i) state_d = INV_WAIT;
         end
         INV_WAIT: begin
            if (cmd_done_i) begin
               state_d = ACK;
            end else if (wdg_exp) begin
               state_d = ACK;
               err_d   = 1'b1;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      wdg_d = 16'd0;
      if ((state_d == state_q) && wdg_run) wdg_d = wdg_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         wdg_q       <= 16'd0;
         flush_cnt_q <= 16'd0;
         is_fencei_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wdg_q       <= wdg_d;
         flush_cnt_q <= flush_cnt_d;
         is_fencei_q <= is_fencei_d;
         err_q       <= err_d;
      end
   end

   // Outputs come only from registers so inputs never reach them combinationally.
   assign cmd_valid_o = (state_q == FLUSH_REQ) || (state_q == INV_REQ);
   assign cmd_op_o    = (state_q == INV_REQ);
   assign fence_ack_o = (state_q == ACK);
   assign err_o       = err_q;
   assign busy_o      = (state_q != IDLE);
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hpdcache_fence_seq.sv
// Directed bench for hpdcache_fence_seq: instance A uses default parameters,
// instance B has FlushOnFence=0, InvalidateOnFlush=1 and an 8-cycle watchdog.
module tb_hpdcache_fence_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic a_req, a_fi, a_sb, a_rdy, a_done;
   logic a_vld, a_op, a_ack, a_err, a_busy;
   logic [15:0] a_cnt;
   logic b_req, b_fi, b_sb, b_rdy, b_done;
   logic b_vld, b_op, b_ack, b_err, b_busy;
   logic [15:0] b_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   hpdcache_fence_seq #(.FlushOnFence(1'b1), .InvalidateOnFlush(1'b0), .TimeoutCycles(1024)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .fence_req_i(a_req), .fence_i_i(a_fi), .sb_empty_i(a_sb),
      .cmd_valid_o(a_vld), .cmd_op_o(a_op), .cmd_ready_i(a_rdy), .cmd_done_i(a_done),
      .fence_ack_o(a_ack), .err_o(a_err), .busy_o(a_busy), .flush_cnt_o(a_cnt));

   hpdcache_fence_seq #(.FlushOnFence(1'b0), .InvalidateOnFlush(1'b1), .TimeoutCycles(8)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .fence_req_i(b_req), .fence_i_i(b_fi), .sb_empty_i(b_sb),
      .cmd_valid_o(b_vld), .cmd_op_o(b_op), .cmd_ready_i(b_rdy), .cmd_done_i(b_done),
      .fence_ack_o(b_ack), .err_o(b_err), .busy_o(b_busy), .flush_cnt_o(b_cnt));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Full fence on instance A with sb empty, ready high and done 2 cycles after accept.
   task automatic fence_a();
      a_req = 1'b1; a_fi = 1'b0;
      tick(); a_req = 1'b0;
      tick();
      tick();
      tick(); a_done = 1'b1;
      tick(); a_done = 1'b0;
      chk("fa_ack", a_ack, 1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int acks;
      rst_n = 1'b0;
      a_req = 0; a_fi = 0; a_sb = 1; a_rdy = 1; a_done = 0;
      b_req = 0; b_fi = 0; b_sb = 1; b_rdy = 0; b_done = 0;
      tick(); tick();
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_vld", a_vld, 0);
      chk("rst_a_cnt", a_cnt, 0);
      chk("rst_b_ack", b_ack, 0);
      rst_n = 1'b1;
      tick();

      // A: single FLUSH, ack at cycle 6
      a_req = 1'b1;
      tick(); a_req = 1'b0;
      chk("a35_c1_busy", a_busy, 1);
      chk("a35_c1_vld", a_vld, 0);
      tick();
      chk("a35_c2_vld", a_vld, 1);
      chk("a35_c2_op", a_op, 0);
      tick();
      chk("a35_c3_vld", a_vld, 0);
      chk("a35_c3_cnt", a_cnt, 1);
      tick();
      tick(); a_done = 1'b1;
      chk("a35_c5_ack", a_ack, 0);
      tick(); a_done = 1'b0;
      chk("a35_c6_ack", a_ack, 1);
      chk("a35_c6_err", a_err, 0);
      tick();
      chk("a35_c7_ack", a_ack, 0);
      chk("a35_c7_busy", a_busy, 0);

      // B: plain fence skips flush, ack at cycle 2
      b_req = 1'b1; b_fi = 1'b0;
      tick(); b_req = 1'b0;
      chk("b36_c1_vld", b_vld, 0);
      tick();
      chk("b36_c2_ack", b_ack, 1);
      chk("b36_c2_vld", b_vld, 0);
      tick();
      chk("b36_c3_busy", b_busy, 0);

      // B: fence.i with ready held low for 5 cycles, then FLUSH + INVAL
      b_req = 1'b1; b_fi = 1'b1;
      tick(); b_req = 1'b0; b_fi = 1'b0;
      for (int c = 2; c <= 6; c++) begin
         tick();
         chk("b37_hold_vld", b_vld, 1);
         chk("b37_hold_op", b_op, 0);
         chk("b37_hold_cnt", b_cnt, 0);
      end
      b_rdy = 1'b1;
      tick(); b_rdy = 1'b0;
      chk("b37_fw_vld", b_vld, 0);
      chk("b37_fw_cnt", b_cnt, 1);
      b_done = 1'b1;
      tick(); b_done = 1'b0;
      chk("b37_inv_vld", b_vld, 1);
      chk("b37_inv_op", b_op, 1);
      tick();
      chk("b37_inv_hold_op", b_op, 1);
      b_rdy = 1'b1;
      tick(); b_rdy = 1'b0;
      chk("b37_iw_vld", b_vld, 0);
      chk("b37_iw_cnt", b_cnt, 1);
      b_done = 1'b1;
      tick(); b_done = 1'b0;
      chk("b37_ack", b_ack, 1);
      chk("b37_err", b_err, 0);
      tick();
      chk("b37_idle", b_busy, 0);

      // B: store buffer never drains, watchdog fires 8 cycles after DRAIN entry
      b_sb = 1'b0; b_req = 1'b1;
      tick(); b_req = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         chk("b38_wait_ack", b_ack, 0);
         chk("b38_wait_vld", b_vld, 0);
         tick();
      end
      chk("b38_ack", b_ack, 1);
      chk("b38_err", b_err, 1);
      tick();
      chk("b38_post_err", b_err, 0);
      chk("b38_post_busy", b_busy, 0);

      // B: drain completes in the same cycle the watchdog expires
      b_req = 1'b1;
      tick(); b_req = 1'b0;
      for (int c = 1; c <= 7; c++) tick();
      b_sb = 1'b1;
      tick();
      chk("b31_ack", b_ack, 1);
      chk("b31_err", b_err, 0);
      tick();

      // A: reset while the FLUSH command is pending
      a_rdy = 1'b0; a_req = 1'b1;
      tick(); a_req = 1'b0;
      tick();
      chk("a39_pend_vld", a_vld, 1);
      rst_n = 1'b0;
      tick();
      chk("a39_rst_vld", a_vld, 0);
      chk("a39_rst_busy", a_busy, 0);
      chk("a39_rst_ack", a_ack, 0);
      chk("a39_rst_cnt", a_cnt, 0);
      rst_n = 1'b1; a_rdy = 1'b1;
      tick();

      // A: second request during FLUSH_WAIT is dropped
      acks = 0;
      a_req = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (c == 1) a_req = 1'b0;
         if (c == 3) a_req = 1'b1;
         if (c == 4) begin a_req = 1'b0; a_done = 1'b1; end
         if (c == 5) a_done = 1'b0;
         if (c == 5) chk("a39_ack_c5", a_ack, 1);
         acks += int'(a_ack);
      end
      chk("a39_one_ack", acks, 1);
      chk("a39_cnt", a_cnt, 1);

      // A: counter saturation from a forced 16'hFFFE
      force u_a.flush_cnt_q = 16'hFFFE;
      #1;
      release u_a.flush_cnt_q;
      tick();
      fence_a();
      chk("a40_cnt_1", a_cnt, 16'hFFFF);
      fence_a();
      chk("a40_cnt_sat", a_cnt, 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
